// File: rtl/gfx_pkg.sv
// Shared graphics-controller definitions: VRAM geometry and requester IDs.
package gfx_pkg;

  localparam int unsigned VRAM_ADDR_W = 10;
  localparam int unsigned VRAM_DATA_W = 16;

  // Requester identity, also used as the index into grant vectors.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_GPU = 1'b1
  } req_id_e;

endpackage

// File: rtl/vram_rr_grant.sv
// Combinational winner selection between the CPU and GPU VRAM requesters.
module vram_rr_grant
  import gfx_pkg::*;
(
  input  logic       cpu_req_i,
  input  logic       gpu_req_i,
  input  logic       gpu_lock_i,
  input  req_id_e    last_winner_i,
  input  logic       burst_max_i,
  output logic [1:0] gnt_o
);

  // Single requester wins outright; contention resolved by lock/burst, else round-robin.
  always_comb begin
    gnt_o = '0;
    if (cpu_req_i && gpu_req_i) begin
      if (gpu_lock_i) begin
        if (burst_max_i) gnt_o[REQ_CPU] = 1'b1;
        else             gnt_o[REQ_GPU] = 1'b1;
      end else if (last_winner_i == REQ_GPU) begin
        gnt_o[REQ_CPU] = 1'b1;
      end else begin
        gnt_o[REQ_GPU] = 1'b1;
      end
    end else if (cpu_req_i) begin
      gnt_o[REQ_CPU] = 1'b1;
    end else if (gpu_req_i) begin
      gnt_o[REQ_GPU] = 1'b1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Per-cycle arbiter sharing the single-port VRAM between the CPU port and the GPU.
module vram_arbiter #(
  parameter int unsigned ADDR_W    = gfx_pkg::VRAM_ADDR_W,
  parameter int unsigned DATA_W    = gfx_pkg::VRAM_DATA_W,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CPU_REQ,
  input  logic              CPU_WRITE,
  input  logic [15:0]       CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DATA_W,
  output logic              CPU_GNT,
  output logic              CPU_RVALID,
  output logic [DATA_W-1:0] CPU_DATA_R,
  input  logic              GPU_REQ,
  input  logic              GPU_WRITE,
  input  logic [ADDR_W-1:0] GPU_ADDR,
  input  logic [DATA_W-1:0] GPU_DATA_W,
  output logic              GPU_GNT,
  output logic              GPU_RVALID,
  output logic [DATA_W-1:0] GPU_DATA_R,
  input  logic              GPU_LOCK,
  output logic              VRAM_ENABLE,
  output logic              VRAM_WRITE,
  output logic [ADDR_W-1:0] VRAM_ADDR,
  output logic [DATA_W-1:0] VRAM_DATA_W,
  input  logic [DATA_W-1:0] VRAM_DATA_R
);

  import gfx_pkg::*;

  localparam int unsigned    BW          = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]  BURST_LIMIT = BW'(MAX_BURST);

  logic [1:0]    gnt;
  logic          cpu_gnt;
  logic          gpu_gnt;
  logic          burst_max;
  req_id_e       last_winner_q, last_winner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          gpu_rvalid_q, gpu_rvalid_d;
  logic          unused_cpu_addr;

  assign unused_cpu_addr = ^CPU_ADDR[15:ADDR_W];
  assign burst_max       = (burst_q == BURST_LIMIT);

  // Requests are masked during reset so nothing is granted or issued to the VRAM.
  vram_rr_grant u_grant (
    .cpu_req_i     (CPU_REQ & ~RESET),
    .gpu_req_i     (GPU_REQ & ~RESET),
    .gpu_lock_i    (GPU_LOCK),
    .last_winner_i (last_winner_q),
    .burst_max_i   (burst_max),
    .gnt_o         (gnt)
  );

  assign cpu_gnt = gnt[REQ_CPU];
  assign gpu_gnt = gnt[REQ_GPU];
  assign CPU_GNT = cpu_gnt;
  assign GPU_GNT = gpu_gnt;

  // Next-state for round-robin pointer, lock burst counter and read-valid flags.
  always_comb begin
    last_winner_d = last_winner_q;
    burst_d       = burst_q;
    if (cpu_gnt)      last_winner_d = REQ_CPU;
    else if (gpu_gnt) last_winner_d = REQ_GPU;
    if (!GPU_LOCK || cpu_gnt) begin
      burst_d = '0;
    end else if (gpu_gnt && CPU_REQ && !burst_max) begin
      burst_d = burst_q + 1'b1;
    end
    cpu_rvalid_d = cpu_gnt & ~CPU_WRITE;
    gpu_rvalid_d = gpu_gnt & ~GPU_WRITE;
  end

  // Registered arbitration state with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_winner_q <= REQ_GPU;
      burst_q       <= '0;
      cpu_rvalid_q  <= 1'b0;
      gpu_rvalid_q  <= 1'b0;
    end else begin
      last_winner_q <= last_winner_d;
      burst_q       <= burst_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      gpu_rvalid_q  <= gpu_rvalid_d;
    end
  end

  // VRAM payload mux: winner's request passes through, idle cycles drive zeros.
  always_comb begin
    VRAM_ENABLE = 1'b0;
    VRAM_WRITE  = 1'b0;
    VRAM_ADDR   = '0;
    VRAM_DATA_W = '0;
    if (cpu_gnt) begin
      VRAM_ENABLE = 1'b1;
      VRAM_WRITE  = CPU_WRITE;
      VRAM_ADDR   = CPU_ADDR[ADDR_W-1:0];
      VRAM_DATA_W = CPU_DATA_W;
    end else if (gpu_gnt) begin
      VRAM_ENABLE = 1'b1;
      VRAM_WRITE  = GPU_WRITE;
      VRAM_ADDR   = GPU_ADDR;
      VRAM_DATA_W = GPU_DATA_W;
    end
  end

  // A read in flight when reset rises must not surface, so RESET also masks the flag output.
  assign CPU_RVALID = cpu_rvalid_q & ~RESET;
  assign GPU_RVALID = gpu_rvalid_q & ~RESET;
  assign CPU_DATA_R = VRAM_DATA_R;
  assign GPU_DATA_R = VRAM_DATA_R;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Cycle-by-cycle arbiter that shares the single-port VRAM between the CPU-side memory controller port and the GPU. It replaces the static lock multiplexer in the graphics controller. It gives per-access grants, round-robin fairness, GPU burst priority with a starvation bound, and per-requester read-data valid strobes. It sits between the two requesters and the VRAM instance inside the graphics controller.

## Interface
- ADDR_W, 10, VRAM word-address width
- DATA_W, 16, VRAM data width
- MAX_BURST, 8, max consecutive contended GPU grants under lock before CPU is forced in (≥1)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- CPU_REQ  in  1  CPU access request
- CPU_WRITE  in  1  1=write, 0=read
- CPU_ADDR  in  16  memory-controller address; bits [ADDR_W-1:0] used
- CPU_DATA_W  in  DATA_W  write data
- CPU_GNT  out  1  access accepted this cycle (combinational)
- CPU_RVALID  out  1  CPU_DATA_R valid (read issued previous cycle)
- CPU_DATA_R  out  DATA_W  read data
- GPU_REQ, GPU_WRITE, GPU_ADDR[ADDR_W-1:0], GPU_DATA_W, GPU_GNT, GPU_RVALID, GPU_DATA_R  same semantics for the GPU
- GPU_LOCK  in  1  GPU burst priority request
- VRAM_ENABLE  out  1  VRAM enable
- VRAM_WRITE  out  1  VRAM write strobe
- VRAM_ADDR  out  ADDR_W  VRAM address
- VRAM_DATA_W  out  DATA_W  VRAM write data
- VRAM_DATA_R  in  DATA_W  VRAM read data (registered, 1-cycle latency)

## Operation
- Per cycle, at most one requester is granted. The grant decision is combinational from the REQ inputs, GPU_LOCK, and the registered state (last_winner, burst_cnt).
- Exactly one REQ high: that requester wins.
- Both high, GPU_LOCK=1, burst_cnt<MAX_BURST: GPU wins.
- Both high, GPU_LOCK=1, burst_cnt==MAX_BURST: CPU wins.
- Both high, GPU_LOCK=0: winner is the opposite of last_winner (round-robin).
- Neither high: no grant. VRAM_ENABLE=0, VRAM_WRITE=0, VRAM_ADDR=0, VRAM_DATA_W=0.
- The granted requester's WRITE/ADDR/DATA_W pass to the VRAM in the same cycle. GNT high means the request was consumed. The requester may present the next access in the following cycle.
- last_winner updates to the granted requester on every grant. It holds when there is no grant.
- burst_cnt behaviour:
  - Increments, saturating, on a GPU grant while CPU_REQ=1 and GPU_LOCK=1.
  - Clears on any CPU grant or whenever GPU_LOCK=0.
  - Holds otherwise.
  - Width is clog2(MAX_BURST+1).
- GPU_LOCK with GPU_REQ=0 reserves nothing. The slot goes to the CPU if it requests.
- A non-granted requester must hold REQ and its payload stable until GNT.
- RVALID: a registered flag set for one cycle after a granted read. Granted writes never raise RVALID.
- CPU_DATA_R and GPU_DATA_R both equal VRAM_DATA_R. Their values are don't-care unless the matching RVALID is high.

## Timing
- Reset values: last_winner=GPU, so the CPU wins the first unlocked contention. burst_cnt=0. CPU_RVALID=GPU_RVALID=0. GNT/VRAM outputs follow the combinational rules with registered state at reset values.
- GNT: 0-cycle latency. Read data: RVALID exactly 1 cycle after GNT.
- Throughput: one access per cycle total. A single requester alone sustains back-to-back accesses.
- RESET high while an access is in flight: the pending RVALID is dropped (0 next cycle). While RESET=1, GNT and VRAM_ENABLE are 0.
- MAX_BURST=1: under lock, contended grants alternate GPU, CPU, GPU, ...

## Structure
- Shared package gfx_pkg:
  - VRAM_ADDR_W=10 and VRAM_DATA_W=16
  - requester IDs REQ_CPU=1'b0, REQ_GPU=1'b1
- One natural sub-module: vram_rr_grant. It is the combinational winner selection (REQs, lock, last_winner, burst_cnt==MAX_BURST → grant vector).
- The top level holds last_winner, burst_cnt, the RVALID registers, and the VRAM payload mux.

## Test plan
- Reset, then CPU read at addr 0x005 with VRAM preloaded with 0xBEEF → CPU_GNT in the same cycle, CPU_RVALID+CPU_DATA_R=0xBEEF next cycle, GPU_RVALID=0.
- Both request continuously, GPU_LOCK=0 → grants alternate CPU, GPU, CPU, GPU starting with CPU. VRAM_ADDR alternates between the two addresses.
- GPU_LOCK=1 and both request continuously, MAX_BURST=8 → 8 GPU grants, 1 CPU grant, 8 GPU grants, and so on. burst_cnt peaks at 8.
- GPU writes 0x1234 to 0x3FF, then CPU reads 0x3FF → GPU_RVALID stays 0. CPU reads 0x1234.
- GPU_LOCK=1, GPU_REQ=0, CPU_REQ=1 → CPU granted every cycle, burst_cnt stays 0.
- Read granted, then RESET asserted in the following cycle → no RVALID. After reset deassertion the first contended grant goes to the CPU.
